// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : IDLE/FETCH/EXEC program-counter sequencer with branch/jump
//                resolution, misaligned-target trap and retired-instr counter.
// Revision     : 1.0
// ============================================================================
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ack_i,
  input  logic             exec_valid_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic             jalr_i,
  input  logic [2:0]       branch_type_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic             fetch_req_o,
  output logic [XLEN-1:0]  fetch_addr_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  link_o,
  output logic             taken_o,
  output logic             trap_o,
  output logic [XLEN-1:0]  epc_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [XLEN-1:0]  r_pc, w_pc_nxt;
  logic [XLEN-1:0]  r_epc, w_epc_nxt;
  logic             r_fetch_req, w_fetch_req_nxt;
  logic             r_taken, w_taken_nxt;
  logic             r_trap, w_trap_nxt;
  logic [CNT_W-1:0] r_instret, w_instret_nxt;

  logic             w_cond;
  logic             w_redirect;
  logic             w_misalign;
  logic             w_resolve;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_seq_pc;
  logic [XLEN-1:0]  w_rel_pc;
  logic [XLEN-1:0]  w_jalr_pc;

  assign w_seq_pc  = r_pc + XLEN'(4);
  assign w_rel_pc  = r_pc + imm_i;
  assign w_jalr_pc = (rs1_i + imm_i) & ~XLEN'(1);
  assign w_resolve = (r_state == S_EXEC) && exec_valid_i && !stall_i;

  // Encodings 010/011 are not branches and fall to not-taken.
  always_comb begin
    w_cond = 1'b0;
    case (branch_type_i)
      3'b000:  w_cond = (rs1_i == rs2_i);
      3'b001:  w_cond = (rs1_i != rs2_i);
      3'b100:  w_cond = ($signed(rs1_i) <  $signed(rs2_i));
      3'b101:  w_cond = ($signed(rs1_i) >= $signed(rs2_i));
      3'b110:  w_cond = (rs1_i <  rs2_i);
      3'b111:  w_cond = (rs1_i >= rs2_i);
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_redirect = 1'b1;
    w_target   = w_seq_pc;
    if (jalr_i) begin
      w_target = w_jalr_pc;
    end else if (jump_i || (branch_i && w_cond)) begin
      w_target = w_rel_pc;
    end else begin
      w_redirect = 1'b0;
    end
  end

  assign w_misalign = w_redirect && w_target[1];

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_epc_nxt       = r_epc;
    w_fetch_req_nxt = r_fetch_req;
    w_taken_nxt     = 1'b0;
    w_trap_nxt      = 1'b0;
    w_instret_nxt   = r_instret;
    case (r_state)
      S_IDLE: begin
        w_state_nxt     = S_FETCH;
        w_fetch_req_nxt = 1'b1;
      end
      S_FETCH: begin
        if (fetch_ack_i) begin
          w_state_nxt     = S_EXEC;
          w_fetch_req_nxt = 1'b0;
        end
      end
      S_EXEC: begin
        if (w_resolve) begin
          w_state_nxt     = S_FETCH;
          w_fetch_req_nxt = 1'b1;
          if (w_misalign) begin
            w_pc_nxt   = TRAP_VECTOR;
            w_epc_nxt  = r_pc;
            w_trap_nxt = 1'b1;
          end else begin
            w_pc_nxt      = w_target;
            w_taken_nxt   = w_redirect;
            w_instret_nxt = r_instret + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_fetch_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_VECTOR;
      r_epc       <= '0;
      r_fetch_req <= 1'b0;
      r_taken     <= 1'b0;
      r_trap      <= 1'b0;
      r_instret   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_epc       <= w_epc_nxt;
      r_fetch_req <= w_fetch_req_nxt;
      r_taken     <= w_taken_nxt;
      r_trap      <= w_trap_nxt;
      r_instret   <= w_instret_nxt;
    end
  end

  assign fetch_req_o  = r_fetch_req;
  assign fetch_addr_o = r_pc;
  assign pc_o         = r_pc;
  assign link_o       = r_pc + XLEN'(4);
  assign taken_o      = r_taken;
  assign trap_o       = r_trap;
  assign epc_o        = r_epc;
  assign instret_o    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// tb_pc_sequencer : directed stimulus, per-cycle reference model plus literal checkpoints.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ack_i, exec_valid_i, stall_i;
  logic        branch_i, jump_i, jalr_i;
  logic [2:0]  branch_type_i;
  logic [31:0] rs1_i, rs2_i, imm_i;
  logic        fetch_req_o, taken_o, trap_o;
  logic [31:0] fetch_addr_o, pc_o, link_o, epc_o, instret_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h0000_0100), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_ack_i(fetch_ack_i), .exec_valid_i(exec_valid_i), .stall_i(stall_i),
    .branch_i(branch_i), .jump_i(jump_i), .jalr_i(jalr_i),
    .branch_type_i(branch_type_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .fetch_req_o(fetch_req_o), .fetch_addr_o(fetch_addr_o), .pc_o(pc_o),
    .link_o(link_o), .taken_o(taken_o), .trap_o(trap_o), .epc_o(epc_o),
    .instret_o(instret_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the instruction life cycle and architectural values.
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_EXEC = 2;
  int          m_phase;
  bit          m_valid = 1'b0;
  bit          m_req, m_taken, m_trap, m_redirect;
  logic [31:0] m_pc, m_epc, m_instret, m_tgt, m_link;

  function automatic bit br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return ua < ub;
      3'd7:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_phase = PH_IDLE; m_pc = 32'h0; m_epc = 32'h0;
      m_instret = 32'h0; m_req = 1'b0; m_taken = 1'b0; m_trap = 1'b0;
    end else if (m_valid) begin
      m_taken = 1'b0;
      m_trap  = 1'b0;
      if (m_phase == PH_IDLE) begin
        m_phase = PH_FETCH;
      end else if (m_phase == PH_FETCH) begin
        if (fetch_ack_i) m_phase = PH_EXEC;
      end else if (exec_valid_i && !stall_i) begin
        m_redirect = 1'b1;
        if (jalr_i)                                            m_tgt = (rs1_i + imm_i) & 32'hFFFF_FFFE;
        else if (jump_i)                                       m_tgt = m_pc + imm_i;
        else if (branch_i && br_taken(branch_type_i, rs1_i, rs2_i)) m_tgt = m_pc + imm_i;
        else begin m_tgt = m_pc + 32'd4; m_redirect = 1'b0; end
        if (m_redirect && m_tgt[1]) begin
          m_epc = m_pc; m_pc = 32'h0000_0100; m_trap = 1'b1;
        end else begin
          m_pc = m_tgt; m_taken = m_redirect; m_instret = m_instret + 32'd1;
        end
        m_phase = PH_FETCH;
      end
      m_req = (m_phase == PH_FETCH);
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      m_link = m_pc + 32'd4;
      chk("pc",         pc_o,         m_pc);
      chk("fetch_addr", fetch_addr_o, m_pc);
      chk("link",       link_o,       m_link);
      chk("fetch_req",  fetch_req_o,  m_req);
      chk("taken",      taken_o,      m_taken);
      chk("trap",       trap_o,       m_trap);
      chk("epc",        epc_o,        m_epc);
      chk("instret",    instret_o,    m_instret);
    end
  end

  task automatic clear_ctl();
    exec_valid_i = 0; stall_i = 0; branch_i = 0; jump_i = 0; jalr_i = 0;
    branch_type_i = 3'd0; rs1_i = 0; rs2_i = 0; imm_i = 0;
  endtask

  task automatic do_fetch();
    int n;
    n = 0;
    while (!fetch_req_o && n < 8) begin @(negedge clk); n++; end
    chk("fetch_req_seen", fetch_req_o, 1'b1);
    fetch_ack_i = 1'b1;
    @(negedge clk);
    fetch_ack_i = 1'b0;
    chk("req_low_after_ack", fetch_req_o, 1'b0);
  endtask

  task automatic do_exec(input bit jl, input bit jp, input bit br, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    exec_valid_i = 1; jalr_i = jl; jump_i = jp; branch_i = br;
    branch_type_i = f3; rs1_i = a; rs2_i = b; imm_i = im;
    @(negedge clk);
    clear_ctl();
  endtask

  task automatic step(input string nm, input bit jl, input bit jp, input bit br, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                      input logic [31:0] epc, input bit etk, input bit etr);
    do_fetch();
    do_exec(jl, jp, br, f3, a, b, im);
    chk({nm, "_pc"},    pc_o,    epc);
    chk({nm, "_taken"}, taken_o, etk);
    chk({nm, "_trap"},  trap_o,  etr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; fetch_ack_i = 0; clear_ctl();
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_req", fetch_req_o, 1'b0);
    chk("rst_instret", instret_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    rst = 0;

    step("seq1", 0, 0, 0, 3'd0, 0, 0, 0, 32'h4, 0, 0);
    step("seq2", 0, 0, 0, 3'd0, 0, 0, 0, 32'h8, 0, 0);
    step("seq3", 0, 0, 0, 3'd0, 0, 0, 0, 32'hC, 0, 0);
    chk("instret_after3", instret_o, 32'd3);
    step("seq4", 0, 0, 0, 3'd0, 0, 0, 0, 32'h10, 0, 0);

    step("beq", 0, 0, 1, 3'd0, 32'd5, 32'd5, 32'hFFFF_FFF8, 32'h8, 1, 0);
    @(negedge clk);
    chk("beq_pulse_end", taken_o, 1'b0);
    step("seq5", 0, 0, 0, 3'd0, 0, 0, 0, 32'hC, 0, 0);
    step("seq6", 0, 0, 0, 3'd0, 0, 0, 0, 32'h10, 0, 0);
    step("bne", 0, 0, 1, 3'd1, 32'd5, 32'd5, 32'hFFFF_FFF8, 32'h14, 0, 0);

    step("blt",  0, 0, 1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h1C, 1, 0);
    step("bltu", 0, 0, 1, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h20, 0, 0);

    step("jalr_trap", 1, 0, 0, 3'd0, 32'h103, 0, 32'h0, 32'h100, 0, 1);
    chk("trap_epc", epc_o, 32'h20);
    chk("trap_instret", instret_o, 32'd10);

    step("f3_010", 0, 0, 1, 3'd2, 32'd7, 32'd7, 32'd8, 32'h104, 0, 0);
    step("jal_top", 0, 1, 0, 3'd0, 0, 0, 32'hFFFF_FEF8, 32'hFFFF_FFFC, 1, 0);
    step("wrap", 0, 0, 0, 3'd0, 0, 0, 0, 32'h0, 0, 0);
    chk("wrap_instret", instret_o, 32'd13);

    do_fetch();
    exec_valid_i = 1; jump_i = 1; branch_i = 1; imm_i = 32'h40; stall_i = 1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_pc", pc_o, 32'h0);
      chk("stall_taken", taken_o, 1'b0);
    end
    stall_i = 0;
    @(negedge clk);
    clear_ctl();
    chk("stall_rel_pc", pc_o, 32'h40);
    chk("stall_rel_taken", taken_o, 1'b1);
    @(negedge clk);
    chk("stall_rel_pulse_end", taken_o, 1'b0);

    exec_valid_i = 1; jump_i = 1; imm_i = 32'h80;
    repeat (2) @(negedge clk);
    clear_ctl();
    chk("exec_in_fetch_ignored", pc_o, 32'h40);
    do_fetch();
    fetch_ack_i = 1;
    @(negedge clk);
    fetch_ack_i = 0;
    do_exec(0, 0, 0, 3'd0, 0, 0, 0);
    chk("ack_in_exec_ignored", pc_o, 32'h44);
    chk("instret_15", instret_o, 32'd15);

    chk("pre_rst_req", fetch_req_o, 1'b1);
    fetch_ack_i = 1; rst = 1;
    @(negedge clk);
    fetch_ack_i = 0; rst = 0;
    chk("abort_pc", pc_o, 32'h0);
    chk("abort_instret", instret_o, 32'h0);
    chk("abort_req", fetch_req_o, 1'b0);
    step("post_rst", 0, 0, 0, 3'd0, 0, 0, 0, 32'h4, 0, 0);
    chk("post_rst_instret", instret_o, 32'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
